// File: rtl/turnstile_check_arbiter.sv
// rtl/turnstile_check_arbiter.sv - round-robin arbiter sharing one code checker across four turnstile gates
module turnstile_check_arbiter #(
    parameter logic [3:0] TIMEOUT = 4'd15
) (
    input  logic        clk,
    input  logic        rset,
    input  logic [3:0]  req,
    input  logic [15:0] code_bus,
    input  logic        chk_ready,
    input  logic        chk_valid,
    input  logic        chk_pass,
    output logic        chk_start,
    output logic [3:0]  chk_code,
    output logic [3:0]  grant,
    output logic [3:0]  done,
    output logic [3:0]  pass,
    output logic [1:0]  state_out
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ISSUE   = 2'b01,
        WAIT    = 2'b10,
        RESPOND = 2'b11
    } state_t;

    state_t      state;
    state_t      state_nxt;

    // Transaction context: who is being served, with what code, and the verdict.
    logic [1:0]  ptr;
    logic [1:0]  idx;
    logic [3:0]  code_l;
    logic [3:0]  timer;
    logic        verdict;

    // Round-robin search result for the current request vector.
    logic        req_any;
    logic        found;
    logic [1:0]  cand;
    logic [1:0]  pick_idx;

    // Timeout fires only when the checker stays silent for the full window.
    logic        wait_timeout;

    assign req_any      = |req;
    assign wait_timeout = (timer == TIMEOUT);

    // Search gates ptr, ptr+1, ... (mod 4) and take the first one requesting.
    always_comb begin
        pick_idx = ptr;
        found    = 1'b0;
        cand     = ptr;
        for (int i = 0; i < 4; i++) begin
            cand = ptr + 2'(i);
            if (!found && req[cand]) begin
                pick_idx = cand;
                found    = 1'b1;
            end
        end
    end

    // State register; reset drops any transaction in flight.
    always_ff @(posedge clk or negedge rset) begin
        if (!rset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decision; checker handshakes only matter in their own state.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_any) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (chk_ready) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (chk_valid || wait_timeout) begin
                    state_nxt = RESPOND;
                end
            end
            RESPOND: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Transaction context: latch winner in IDLE, time the WAIT, capture verdict, rotate pointer.
    always_ff @(posedge clk or negedge rset) begin
        if (!rset) begin
            ptr     <= 2'd0;
            idx     <= 2'd0;
            code_l  <= 4'd0;
            timer   <= 4'd0;
            verdict <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_any) begin
                        idx    <= pick_idx;
                        code_l <= code_bus[{pick_idx, 2'b00} +: 4];
                    end
                end
                ISSUE: begin
                    // Timer starts from zero on the first WAIT cycle.
                    if (chk_ready) begin
                        timer <= 4'd0;
                    end
                end
                WAIT: begin
                    timer <= timer + 4'd1;
                    // A result arriving on the timeout cycle still wins.
                    if (chk_valid) begin
                        verdict <= chk_pass;
                    end else if (wait_timeout) begin
                        verdict <= 1'b0;
                    end
                end
                RESPOND: begin
                    // Next search starts just past the gate we served.
                    ptr <= idx + 2'd1;
                end
                default: begin
                    ptr <= ptr;
                end
            endcase
        end
    end

    // Outputs decoded from the current state and latched context.
    always_comb begin
        chk_start = 1'b0;
        chk_code  = 4'd0;
        grant     = 4'd0;
        done      = 4'd0;
        pass      = 4'd0;
        state_out = state;
        case (state)
            ISSUE: begin
                chk_start  = 1'b1;
                chk_code   = code_l;
                grant[idx] = 1'b1;
            end
            WAIT: begin
                grant[idx] = 1'b1;
            end
            RESPOND: begin
                grant[idx] = 1'b1;
                done[idx]  = 1'b1;
                pass[idx]  = verdict;
            end
            default: begin
                chk_start = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/turnstile_check_arbiter.md
TURNSTILE_CHECK_ARBITER -- requirements
Module: turnstile_check_arbiter

Parameters
REQ-001 The block SHALL provide parameter TIMEOUT, default 4'd15: maximum WAIT-state cycle count before a forced deny.

Interface
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, with ports as listed below.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rset  input  1  asynchronous active-low reset.
REQ-005 req  input  4  per-gate validation request (level); bit i = gate i.
REQ-006 code_bus  input  16  gate i access code on bits [4i+3:4i].
REQ-007 chk_ready  input  1  shared code checker accepts a start this cycle.
REQ-008 chk_valid  input  1  shared checker result valid.
REQ-009 chk_pass  input  1  checker verdict, 1 = grant; qualified by chk_valid.
REQ-010 chk_start  output  1  start strobe to the checker.
REQ-011 chk_code  output  4  code presented to the checker.
REQ-012 grant  output  4  one-hot: gate currently owning the checker.
REQ-013 done  output  4  one-cycle completion pulse for the served gate.
REQ-014 pass  output  4  verdict for the served gate; valid only when the matching done bit is 1.
REQ-015 state_out  output  2  current FSM state.

Function
REQ-016 The FSM SHALL have states IDLE=2'b00, ISSUE=2'b01, WAIT=2'b10, RESPOND=2'b11; the state register SHALL be registered, and an illegal state SHALL go to IDLE.
REQ-017 IDLE behaviour:
- If any req bit is 1, select a gate round-robin, starting at pointer ptr (2 bits) and searching ptr, ptr+1, ... mod 4.
- Latch the gate index and its 4-bit code.
- Go to ISSUE.
- Otherwise remain in IDLE.
REQ-018 ISSUE behaviour:
- chk_start=1 and chk_code=latched code.
- If chk_ready=1, go to WAIT.
- Otherwise hold in ISSUE with chk_start and chk_code stable.
REQ-019 WAIT behaviour:
- A 4-bit timer SHALL be 0 on entry and increment each WAIT cycle.
- chk_valid=1: latch chk_pass and go to RESPOND.
- chk_valid=0 and timer==TIMEOUT: latch verdict 0 (deny) and go to RESPOND.
- chk_valid=1 in the same cycle as the timeout: chk_valid SHALL take priority.
REQ-020 RESPOND behaviour:
- done[idx]=1 and pass[idx]=latched verdict for exactly one cycle; all other done/pass bits are 0.
- ptr SHALL become idx+1 mod 4 (wraps 3->0).
- Go to IDLE.
REQ-021 grant[idx] SHALL be 1 in ISSUE, WAIT and RESPOND and all-zero in IDLE; at most one bit is ever set.
REQ-022 chk_start SHALL be 1 only in ISSUE; chk_code SHALL be 0 outside ISSUE.
REQ-023 chk_valid and chk_pass SHALL be ignored outside WAIT.
REQ-024 Deasserting req for the granted gate mid-transaction SHALL NOT abort the transaction; done and pass are still produced for it.
REQ-025 A gate whose req is still high after its done SHALL be re-arbitrated as a new request; the rotated ptr ensures other pending gates are served first.
REQ-026 Minimum latency: req sampled in IDLE at cycle t, chk_ready=1, chk_valid=1 on the first WAIT cycle gives chk_start at t+1, done at t+3, and IDLE at t+4.
REQ-027 Worst-case WAIT occupancy SHALL be TIMEOUT+1 cycles.

Reset
REQ-028 On rset=0, asynchronously, the block SHALL:
- set state=IDLE, ptr=0, timer=0, latched index/code/verdict=0;
- drive chk_start, chk_code, grant, done, pass and state_out to 0.
REQ-029 A reset asserted mid-transaction SHALL abandon it with no done pulse; after release, arbitration restarts from gate 0.

Verification
REQ-030 Single request: req=4'b0100, code_bus[11:8]=4'd7, chk_ready=1, chk_valid=1 with chk_pass=1 one cycle after start. Expected: grant=4'b0100, chk_code=7, done=4'b0100, pass=4'b0100, 3 cycles from IDLE sample to done.
REQ-031 Round-robin: req=4'b1111 held continuously with immediate checker responses. Expected service order 0,1,2,3,0 with no gate served twice before all are served.
REQ-032 Backpressure: chk_ready=0 for 5 cycles. Expected: state_out=01 and chk_start=1 for 5 cycles with a stable chk_code, then WAIT after chk_ready=1.
REQ-033 Timeout: chk_valid never asserts. Expected: WAIT lasts 16 cycles, then done pulses with pass=0; a variant with chk_valid=1, chk_pass=1 on the timeout cycle gives pass=1.
REQ-034 Reset mid-WAIT: rset=0 while serving gate 2. Expected: all outputs 0 immediately and no done pulse; after release with req=4'b0110, gate 1 is served first.
